emif_dfh_csr: RTL

- MMIO CSR slave for the EMIF feature: the register block that the HE-MEM loopback test CSR map reads.
- Sits on the BPF/FME MMIO path, beside the EMIF subsystem.
- Returns the EMIF DFH (0x0), calibration status (0x8) and channel capability (0x10).
- Synchronises per-channel calibration flags from the EMIF domain and keeps sticky lost-calibration flags, which software clears with write-1-to-clear (W1C).

---
 rtl/emif_csr_pkg.sv | 33 +++
 rtl/emif_dfh_csr_sync.sv | 25 ++
 rtl/emif_dfh_csr.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/emif_csr_pkg.sv
// Shared types and register-map constants for the EMIF DFH CSR block.
// EMIF_CSR_SCRATCH_EN (optional) enables the scratchpad at 0x18 in emif_dfh_csr.
package emif_csr_pkg;

    typedef struct packed {
        logic [3:0]  feat_type;
        logic [7:0]  rsvd1;
        logic [3:0]  afu_minor_ver;
        logic [6:0]  rsvd0;
        logic        eol;
        logic [23:0] nxt_dfh_offset;
        logic [3:0]  afu_major_ver;
        logic [11:0] feat_id;
    } t_dfh;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_DEC,
        ST_RD_RSP
    } t_csr_state;

    localparam int EMIF_DFH_OFFSET        = 'h00;
    localparam int EMIF_STATUS_OFFSET     = 'h08;
    localparam int EMIF_CAPABILITY_OFFSET = 'h10;
    localparam int EMIF_SCRATCH_OFFSET    = 'h18;

    localparam int STATUS_SUCC_LSB = 0;
    localparam int STATUS_FAIL_LSB = 8;
    localparam int STATUS_LOST_LSB = 16;
    localparam int CAP_SCRATCH_BIT = 63;

endpackage

// File: rtl/emif_dfh_csr_sync.sv
// Per-bit two-flop synchroniser for EMIF-domain calibration flags.
module emif_csr_sync
    import emif_csr_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_async,
    output logic [W-1:0] d_sync
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= '0;
            d_sync <= '0;
        end else begin
            meta   <= d_async;
            d_sync <= meta;
        end
    end

endmodule

// File: rtl/emif_dfh_csr.sv
// EMIF feature CSR slave: DFH, calibration status with W1C lost-cal flags, capability.
// Optional macro EMIF_CSR_SCRATCH_EN adds a RW scratchpad at 0x18 and CAPABILITY[63].
//
// state     | meaning
// ST_INIT   | leaving reset, not yet accepting requests
// ST_IDLE   | req_ready=1; writes apply here, reads move to ST_RD_DEC
// ST_RD_DEC | read address held, read data captured into rsp_data
// ST_RD_RSP | rsp_valid=1 until rsp_ready
module emif_dfh_csr
    import emif_csr_pkg::*;
#(
    parameter int          NUM_CH          = 4,
    parameter int          ADDR_W          = 12,
    parameter logic [7:0]  CH_EN_MASK      = 8'h0F,
    parameter logic [3:0]  DFH_FEAT_TYPE   = 4'h3,
    parameter logic [23:0] DFH_NEXT_OFFSET = 24'h00B000,
    parameter logic        DFH_EOL         = 1'b0,
    parameter logic [3:0]  DFH_MAJOR_VER   = 4'h1,
    parameter logic [11:0] DFH_FEAT_ID     = 12'h009
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_data,
    input  logic [NUM_CH-1:0] cal_success_async,
    input  logic [NUM_CH-1:0] cal_fail_async
);

    localparam int QW_W = ADDR_W - 3;
    localparam logic [QW_W-1:0] QW_DFH     = QW_W'(EMIF_DFH_OFFSET >> 3);
    localparam logic [QW_W-1:0] QW_STATUS  = QW_W'(EMIF_STATUS_OFFSET >> 3);
    localparam logic [QW_W-1:0] QW_CAP     = QW_W'(EMIF_CAPABILITY_OFFSET >> 3);
`ifdef EMIF_CSR_SCRATCH_EN
    localparam logic [QW_W-1:0] QW_SCRATCH = QW_W'(EMIF_SCRATCH_OFFSET >> 3);
`endif

    localparam logic [8:0] CH_ALL9  = (9'd1 << NUM_CH) - 9'd1;
    localparam logic [7:0] CAP_MASK = CH_EN_MASK & CH_ALL9[7:0];

    localparam t_dfh DFH_VAL = '{
        feat_type:      DFH_FEAT_TYPE,
        rsvd1:          8'h0,
        afu_minor_ver:  4'h0,
        rsvd0:          7'h0,
        eol:            DFH_EOL,
        nxt_dfh_offset: DFH_NEXT_OFFSET,
        afu_major_ver:  DFH_MAJOR_VER,
        feat_id:        DFH_FEAT_ID
    };

    t_csr_state        state, state_nxt;
    logic [QW_W-1:0]   qw_q;
    logic [QW_W-1:0]   req_qw;
    logic              rd_acc, wr_acc;
    logic [NUM_CH-1:0] succ_sync, fail_sync, succ_d3;
    logic [NUM_CH-1:0] lost_sticky, lost_fall, lost_w1c;
    logic [63:0]       rd_data;
    logic              unused_bits;
`ifdef EMIF_CSR_SCRATCH_EN
    logic [63:0]       scratch;
`endif

    assign unused_bits = ^{req_addr[2:0], req_wdata};

    emif_csr_sync #(.W(NUM_CH)) u_sync_succ (
        .clk     (clk),
        .rst     (rst),
        .d_async (cal_success_async),
        .d_sync  (succ_sync)
    );

    emif_csr_sync #(.W(NUM_CH)) u_sync_fail (
        .clk     (clk),
        .rst     (rst),
        .d_async (cal_fail_async),
        .d_sync  (fail_sync)
    );

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RD_RSP);
    assign req_qw    = req_addr[ADDR_W-1:3];
    assign rd_acc    = req_valid && req_ready && !req_write;
    assign wr_acc    = req_valid && req_ready && req_write;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:   state_nxt = ST_IDLE;
            ST_IDLE:   if (rd_acc) state_nxt = ST_RD_DEC;
            ST_RD_DEC: state_nxt = ST_RD_RSP;
            ST_RD_RSP: if (rsp_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_INIT;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         qw_q <= '0;
        else if (rd_acc) qw_q <= req_qw;
    end

    always_comb begin
        rd_data = '0;
        case (qw_q)
            QW_DFH: rd_data = DFH_VAL;
            QW_STATUS: begin
                rd_data[STATUS_SUCC_LSB +: NUM_CH] = succ_sync;
                rd_data[STATUS_FAIL_LSB +: NUM_CH] = fail_sync;
                rd_data[STATUS_LOST_LSB +: NUM_CH] = lost_sticky;
            end
            QW_CAP: begin
                rd_data[7:0] = CAP_MASK;
`ifdef EMIF_CSR_SCRATCH_EN
                rd_data[CAP_SCRATCH_BIT] = 1'b1;
`endif
            end
`ifdef EMIF_CSR_SCRATCH_EN
            QW_SCRATCH: rd_data = scratch;
`endif
            default: rd_data = '0;
        endcase
    end

    // Snapshot taken once; sticky updates while waiting on rsp_ready are not reflected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     rsp_data <= '0;
        else if (state == ST_RD_DEC) rsp_data <= rd_data;
    end

    // A fall detected in the same cycle as a W1C of that bit wins.
    assign lost_fall = succ_d3 & ~succ_sync;
    assign lost_w1c  = (wr_acc && req_qw == QW_STATUS) ?
                       req_wdata[STATUS_LOST_LSB +: NUM_CH] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            succ_d3     <= '0;
            lost_sticky <= '0;
        end else begin
            succ_d3     <= succ_sync;
            lost_sticky <= (lost_sticky & ~lost_w1c) | lost_fall;
        end
    end

`ifdef EMIF_CSR_SCRATCH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               scratch <= '0;
        else if (wr_acc && req_qw == QW_SCRATCH) scratch <= req_wdata;
    end
`endif

endmodule
